// File: rtl/int_to_float.sv
// Signed 32-bit integer to IEEE-754 single converter: one-bit-per-cycle normalise, then pack.
// Latency 33-k edges for leading one at bit k (1 edge for zero); in_ready_o only in IDLE, no output backpressure.
package float_pkg;
  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [22:0] mant;
  } float_t;
endpackage

module int_to_float #(
  parameter int unsigned ROUND_EN = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [31:0]       in_data_i,
  output logic              wen_o,
  output float_pkg::float_t wdata_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, NORM, PACK} state_t;

  localparam logic RoundOn = (ROUND_EN != 0);

  state_t            state_q, state_d;
  logic              sign_q;
  logic [31:0]       mag_q;
  logic [7:0]        exp_q;
  logic              accept;
  logic              guard, sticky, rnd_up;
  logic [23:0]       mant_sum;
  logic [7:0]        exp_pk;
  float_pkg::float_t pack_word;

  assign in_ready_o = (state_q == IDLE);
  assign busy_o     = (state_q != IDLE);
  assign accept     = in_valid_i && in_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (in_data_i == 32'd0) ? PACK : NORM;
      NORM:    if (mag_q[31]) state_d = PACK;
      PACK:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Round-to-nearest-even on the 8 bits dropped below the 23-bit mantissa;
  // a carry out of the mantissa bumps the exponent.
  always_comb begin
    guard    = mag_q[7];
    sticky   = |mag_q[6:0];
    rnd_up   = RoundOn && guard && (sticky || mag_q[8]);
    mant_sum = {1'b0, mag_q[30:8]} + {23'd0, rnd_up};
    exp_pk   = exp_q + {7'd0, mant_sum[23]};
    pack_word = '0;
    if (mag_q != 32'd0) begin
      pack_word.sign = sign_q;
      pack_word.exp  = exp_pk;
      pack_word.mant = mant_sum[22:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sign_q  <= 1'b0;
      mag_q   <= '0;
      exp_q   <= '0;
      wen_o   <= 1'b0;
      wdata_o <= '0;
    end else begin
      wen_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            sign_q <= in_data_i[31];
            mag_q  <= in_data_i[31] ? (~in_data_i + 32'd1) : in_data_i;
            exp_q  <= 8'd158;
          end
        end
        NORM: begin
          if (!mag_q[31]) begin
            mag_q <= {mag_q[30:0], 1'b0};
            exp_q <= exp_q - 8'd1;
          end
        end
        PACK: begin
          wdata_o <= pack_word;
          wen_o   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_float.sv
// Directed bench for int_to_float: rounding and truncating instances share one input stream.
module tb_int_to_float;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic [31:0]       in_data;
  logic              rdy_r, rdy_t;
  logic              wen_r, wen_t;
  logic              busy_r, busy_t;
  float_pkg::float_t wdata_r, wdata_t;
  logic [31:0]       freg;
  logic              stream_on;
  logic [31:0]       stream_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  int_to_float #(.ROUND_EN(1)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy_r),
    .in_data_i(in_data), .wen_o(wen_r), .wdata_o(wdata_r), .busy_o(busy_r)
  );

  int_to_float #(.ROUND_EN(0)) u_dut_tr (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy_t),
    .in_data_i(in_data), .wen_o(wen_t), .wdata_o(wdata_t), .busy_o(busy_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream float register fed by the rounding instance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)     freg <= 32'd0;
    else if (wen_r) freg <= wdata_r;
  end

  always @(negedge clk) begin
    if (stream_on && wen_r) stream_q.push_back(wdata_r);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: exact double via $itor, then round-to-nearest-even to single.
  function automatic logic [31:0] itof_model(input logic [31:0] v);
    real         r;
    logic [63:0] b;
    logic [51:0] f;
    logic [23:0] m;
    int          e;
    r = $itor($signed(v));
    b = $realtobits(r);
    if (v == 32'd0) return 32'd0;
    f = b[51:0];
    m = {1'b0, f[51:29]};
    if (f[28] && ((|f[27:0]) || f[29])) m = m + 24'd1;
    e = int'(b[62:52]) - 1023 + 127 + int'(m[23]);
    return {b[63], e[7:0], m[22:0]};
  endfunction

  task automatic conv(input logic [31:0] d, input logic [31:0] exp_r, input logic [31:0] exp_t,
                      input int exp_lat, input string tag);
    int n;
    @(negedge clk);
    check({tag, "_rdy"}, {31'd0, rdy_r}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    check({tag, "_busy"}, {31'd0, busy_r}, 32'd1);
    n = 0;
    while (!wen_r && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_rnd"}, wdata_r, exp_r);
    check({tag, "_trn"}, wdata_t, exp_t);
    check({tag, "_wen_t"}, {31'd0, wen_t}, 32'd1);
    check({tag, "_rdy_w"}, {31'd0, rdy_r}, 32'd1);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, {31'd0, wen_r}, 32'd0);
    check({tag, "_hold"}, wdata_r, exp_r);
  endtask

  initial begin
    logic [31:0] sd[5];
    int acc, cyc, pulses;
    logic rdy;

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = 32'd0;
    stream_on = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, rdy_r}, 32'd1);
    check("rst_busy", {31'd0, busy_r}, 32'd0);
    check("rst_wen", {31'd0, wen_r}, 32'd0);
    check("rst_wdata", wdata_r, 32'd0);
    rst_n = 1'b1;

    conv(32'd1,          32'h3F800000, 32'h3F800000, 33, "one");
    conv(32'hFFFFFFFF,   32'hBF800000, 32'hBF800000, 33, "minus_one");
    conv(32'd0,          32'h00000000, 32'h00000000, 1,  "zero");
    conv(32'h80000000,   32'hCF000000, 32'hCF000000, 2,  "int_min");
    conv(32'd16777217,   32'h4B800000, 32'h4B800000, 9,  "tie_even");
    conv(32'd16777219,   32'h4B800002, 32'h4B800001, 9,  "tie_up");
    conv(32'h7FFFFFFF,   32'h4F000000, 32'h4EFFFFFF, 3,  "int_max");
    conv(32'hFFFFFFFB,   32'hC0A00000, 32'hC0A00000, 31, "minus_five");

    // Continuous stream with in_valid held high.
    for (int i = 0; i < 5; i++) sd[i] = $urandom;
    stream_q.delete();
    @(negedge clk);
    stream_on = 1'b1;
    in_valid = 1'b1;
    in_data = sd[0];
    acc = 0;
    cyc = 0;
    while (acc < 5 && cyc < 400) begin
      rdy = rdy_r;
      @(posedge clk);
      cyc++;
      if (rdy) begin
        acc++;
        #1;
        if (acc < 5) in_data = sd[acc];
        else         in_valid = 1'b0;
      end
      @(negedge clk);
    end
    cyc = 0;
    while (busy_r && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    repeat (2) @(negedge clk);
    stream_on = 1'b0;
    pulses = stream_q.size();
    check("stream_accepts", acc, 5);
    check("stream_pulses", pulses, 5);
    for (int i = 0; i < 5 && i < pulses; i++)
      check($sformatf("stream_res%0d", i), stream_q[i], itof_model(sd[i]));
    check("stream_freg", freg, itof_model(sd[4]));

    // Reset in the middle of normalisation abandons the conversion.
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 32'd1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_wdata", wdata_r, 32'd0);
    check("midrst_busy", {31'd0, busy_r}, 32'd0);
    check("midrst_ready", {31'd0, rdy_r}, 32'd1);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (wen_r) pulses++;
    end
    check("midrst_nowen", pulses, 0);
    rst_n = 1'b1;
    conv(32'd2, 32'h40000000, 32'h40000000, 32, "after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
